// File: rtl/ecg_block_packer_if.sv
// Handshake bundle between the ECG sample source, the block packer and the
// whitening stage. The slave modport is the packer's view.
interface ecg_block_packer_if #(
  parameter int SAMPLE_W = 16,
  parameter int BLOCK_W  = 128
);
  localparam int CNTW = $clog2(BLOCK_W / SAMPLE_W) + 1;

  logic                s_valid_i;
  logic                s_ready_o;
  logic [SAMPLE_W-1:0] s_data_i;
  logic                flush_i;
  logic                m_valid_o;
  logic                m_ready_i;
  logic [BLOCK_W-1:0]  m_data_o;
  logic [CNTW-1:0]     m_count_o;
  logic                m_last_o;

  modport slave (
    input  s_valid_i, s_data_i, flush_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o, m_count_o, m_last_o
  );

  modport master (
    output s_valid_i, s_data_i, flush_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o, m_count_o, m_last_o
  );
endinterface

// File: rtl/ecg_block_packer.sv
// Packs streamed ECG samples LSB-first into BLOCK_W blocks; one block in
// assembly plus one in the output register, with flush-driven padding.
module ecg_block_packer #(
  parameter int                  SAMPLE_W  = 16,
  parameter int                  BLOCK_W   = 128,
  parameter logic [SAMPLE_W-1:0] PAD_VALUE = '0
) (
  input logic               clk_i,
  input logic               rst_i,
  ecg_block_packer_if.slave bus
);
  localparam int N    = BLOCK_W / SAMPLE_W;
  localparam int CW   = $clog2(N);
  localparam int CNTW = CW + 1;

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BLOCK_W-1:0]  asm_q, asm_d;
  logic                pend_q, pend_d;
  logic [BLOCK_W-1:0]  data_q, data_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic                last_q, last_d;

  logic                s_ready, s_fire, flush_req, close, can_load;
  logic [CNTW-1:0]     fill;
  logic [BLOCK_W-1:0]  asm_with, padded;

  // Ready depends combinationally on m_ready_i so a full block can pass
  // straight through while the held one drains.
  assign s_ready   = !pend_q && ((cnt_q != CW'(N-1)) || state_q == EMPTY || bus.m_ready_i);
  assign s_fire    = bus.s_valid_i && s_ready;
  assign fill      = {1'b0, cnt_q} + CNTW'(s_fire);
  assign flush_req = bus.flush_i && !pend_q && ((cnt_q != '0) || s_fire);
  assign close     = (s_fire && cnt_q == CW'(N-1)) || flush_req || pend_q;
  assign can_load  = (state_q == EMPTY) || bus.m_ready_i;

  always_comb begin
    asm_with = asm_q;
    padded   = '0;
    for (int k = 0; k < N; k++) begin
      if (s_fire && cnt_q == CW'(k)) asm_with[k*SAMPLE_W +: SAMPLE_W] = bus.s_data_i;
      padded[k*SAMPLE_W +: SAMPLE_W] = (CNTW'(k) < fill) ? asm_with[k*SAMPLE_W +: SAMPLE_W]
                                                         : PAD_VALUE;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = fill[CW-1:0];
    asm_d   = asm_with;
    pend_d  = pend_q;
    data_d  = data_q;
    count_d = count_q;
    last_d  = last_q;
    if (state_q == HOLD && bus.m_ready_i) state_d = EMPTY;
    if (close && can_load) begin
      state_d = HOLD;
      data_d  = padded;
      count_d = fill;
      last_d  = flush_req || pend_q;
      cnt_d   = '0;
      asm_d   = '0;
      pend_d  = 1'b0;
    end else if (close) begin
      // Output busy: park the partial block until the register frees.
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      asm_q   <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign bus.s_ready_o = s_ready;
  assign bus.m_valid_o = (state_q == HOLD);
  assign bus.m_data_o  = data_q;
  assign bus.m_count_o = count_q;
  assign bus.m_last_o  = last_q;
endmodule

// File: tb/tb_ecg_block_packer.sv
// Scoreboarded random/directed bench for ecg_block_packer against a
// sample-queue model of the packing and flush rules.
module tb_ecg_block_packer;
  localparam int SW = 16;
  localparam int BW = 128;
  localparam int N  = BW / SW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ecg_block_packer_if #(.SAMPLE_W(SW), .BLOCK_W(BW)) ifc ();

  ecg_block_packer #(.SAMPLE_W(SW), .BLOCK_W(BW), .PAD_VALUE(16'h0000)) dut (
    .clk_i(clk), .rst_i(rst), .bus(ifc)
  );

  typedef struct {
    logic [BW-1:0] d;
    int            c;
    logic          l;
  } blk_t;

  int total = 0;
  int bad   = 0;
  blk_t exp_q[$];
  logic [SW-1:0] part[$];
  bit pend_m = 0, full_m = 0, acc = 0;

  task automatic chk(string nm, logic [BW-1:0] act, logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: samples accumulate in a queue; a block is the queue contents
  // laid out LSB-first with zero padding.
  task automatic model_step();
    bit rdy, closing, canl;
    blk_t b;
    rdy = !pend_m && (part.size() < N-1 || !full_m || ifc.m_ready_i);
    chk("s_ready", BW'(ifc.s_ready_o), BW'(rdy));
    chk("m_valid", BW'(ifc.m_valid_o), BW'(full_m));
    acc = ifc.s_valid_i && rdy;
    if (acc) part.push_back(ifc.s_data_i);
    closing = part.size() == N || (ifc.flush_i && part.size() > 0) || pend_m;
    canl = !full_m || ifc.m_ready_i;
    if (closing && canl) begin
      b.d = '0;
      foreach (part[i]) b.d[i*SW +: SW] = part[i];
      b.c = part.size();
      b.l = pend_m || ifc.flush_i;
      exp_q.push_back(b);
      part.delete();
      pend_m = 0;
      full_m = 1;
    end else if (closing) begin
      pend_m = 1;
    end else if (full_m && ifc.m_ready_i) begin
      full_m = 0;
    end
  endtask

  task automatic step(bit v, logic [SW-1:0] d, bit f, bit r);
    @(posedge clk); #1;
    ifc.s_valid_i = v;
    ifc.s_data_i  = d;
    ifc.flush_i   = f;
    ifc.m_ready_i = r;
    @(negedge clk);
    model_step();
  endtask

  task automatic send(logic [SW-1:0] d, bit r, bit f = 0);
    int n = 0;
    do begin
      step(1, d, f, r);
      n++;
    end while (!acc && n < 20);
    if (!acc) chk("send_timeout", 1, 0);
  endtask

  task automatic drain();
    repeat (4) step(0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    ifc.s_valid_i = 0; ifc.flush_i = 0; ifc.m_ready_i = 0; ifc.s_data_i = '0;
    @(posedge clk); #1;
    rst = 0;
    part.delete(); exp_q.delete(); pend_m = 0; full_m = 0;
    @(negedge clk);
    chk("rst_m_valid", BW'(ifc.m_valid_o), 0);
    chk("rst_m_data",  ifc.m_data_o, 0);
    chk("rst_m_count", BW'(ifc.m_count_o), 0);
    chk("rst_m_last",  BW'(ifc.m_last_o), 0);
    chk("rst_s_ready", BW'(ifc.s_ready_o), 1);
  endtask

  // Monitor: every presented block must match the scoreboard head, and stay
  // matching while stalled.
  always @(negedge clk) begin
    if (!rst && ifc.m_valid_o) begin
      if (exp_q.size() == 0) chk("unexpected_block", BW'(ifc.m_valid_o), 0);
      else begin
        chk("m_data",  ifc.m_data_o, exp_q[0].d);
        chk("m_count", BW'(ifc.m_count_o), BW'(exp_q[0].c));
        chk("m_last",  BW'(ifc.m_last_o), BW'(exp_q[0].l));
        if (ifc.m_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    ifc.s_valid_i = 0; ifc.flush_i = 0; ifc.m_ready_i = 0; ifc.s_data_i = '0;
    do_reset();

    for (int i = 1; i <= 8; i++) send(SW'(i), 1);
    drain();

    send(16'hA1A1, 1); send(16'hA2A2, 1); send(16'hA3A3, 1);
    step(0, 0, 1, 1);
    drain();

    for (int i = 0; i < 15; i++) send(SW'(16'h1000 + i), 0);
    step(1, 16'h100F, 0, 0);
    step(1, 16'h100F, 0, 0);
    send(16'h100F, 1);
    drain();

    for (int i = 0; i < 7; i++) send(SW'(16'h2000 + i), 1);
    send(16'h2007, 1, 1);
    drain();

    for (int i = 0; i < 8; i++) send(SW'(16'h3000 + i), 0);
    send(16'h3100, 0); send(16'h3101, 0);
    step(0, 0, 1, 0);
    repeat (3) step(1, 16'h3102, 0, 0);
    step(0, 0, 1, 0);
    drain();

    for (int i = 0; i < 8; i++) send(SW'(16'h4000 + i), 0);
    for (int i = 0; i < 5; i++) send(SW'(16'h4100 + i), 0);
    do_reset();
    for (int i = 0; i < 8; i++) send(SW'(16'h5000 + i), 1);
    drain();

    step(0, 0, 1, 1);
    drain();

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, SW'($urandom_range(0, 65535)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
    step(0, 0, 1, 1);
    drain();
    drain();

    chk("scoreboard_empty", BW'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
